tmr_word_scrubber: RTL and testbench

- Producer/storage side of the triplicated-word path: holds one data word as three redundant copies (A, B, C) and drives them to downstream word voters.
- Periodically votes its own copies internally and rewrites all three with the majority word, so single-copy upsets are removed before a second upset makes the word unrecoverable.
- Provides a valid/ready write port, fault-injection inputs for verification, and a saturating corrected-error counter.

---
 rtl/tmr_word_scrubber.sv | 189 ++++++++++++++++++
 tb/tb_tmr_word_scrubber.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_word_scrubber.sv
// Triplicated word store: holds three redundant copies of one word, votes them
// combinationally for downstream use and periodically scrubs them back to the majority.
module tmr_word_scrubber #(
  parameter int DataWidth     = 32,
  parameter int ScrubInterval = 16,
  parameter int CntWidth      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wvalid_i,
  output logic                 wready_o,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [2:0]           inject_i,
  input  logic [DataWidth-1:0] inject_mask_i,
  input  logic                 clr_i,
  output logic [DataWidth-1:0] copy_a_o,
  output logic [DataWidth-1:0] copy_b_o,
  output logic [DataWidth-1:0] copy_c_o,
  output logic [DataWidth-1:0] data_o,
  output logic [2:0]           error_cba_o,
  output logic                 uncorrectable_o,
  output logic                 uncorr_sticky_o,
  output logic [CntWidth-1:0]  corrected_cnt_o,
  output logic                 scrub_busy_o
);

  localparam int IntvW = (ScrubInterval > 1) ? $clog2(ScrubInterval) : 1;
  localparam logic [IntvW-1:0] IntvReload = IntvW'(ScrubInterval - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    REPAIR = 2'd2
  } state_t;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (v == {CntWidth{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IntvW-1:0]     r_intv;
  logic [DataWidth-1:0] r_copy_a, r_copy_b, r_copy_c;
  logic [DataWidth-1:0] r_voted;
  logic                 r_cls_corr, r_cls_uncorr;
  logic                 r_sticky;
  logic [CntWidth-1:0]  r_cnt;

  logic [DataWidth-1:0] w_voted;
  logic [2:0]           w_err;
  logic                 w_uncorr;
  logic                 w_wready, w_busy, w_accept;
  logic [DataWidth-1:0] w_base_a, w_base_b, w_base_c;
  logic [DataWidth-1:0] w_nxt_a, w_nxt_b, w_nxt_c;
  logic                 w_repair_wr;

  // Majority vote over the current copies; the odd copy is flagged one-hot.
  always_comb begin
    w_voted  = r_copy_a;
    w_err    = 3'b000;
    w_uncorr = 1'b0;
    if (r_copy_a == r_copy_b) begin
      if (r_copy_c != r_copy_a) w_err = 3'b100;
    end else if (r_copy_a == r_copy_c) begin
      w_err = 3'b010;
    end else if (r_copy_b == r_copy_c) begin
      w_voted = r_copy_b;
      w_err   = 3'b001;
    end else begin
      w_uncorr = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wready    = 1'b0;
    w_busy      = 1'b1;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_wready = 1'b1;
        w_busy   = 1'b0;
        w_accept = wvalid_i;
        if (!wvalid_i && (r_intv == '0)) w_state_nxt = CHECK;
      end
      CHECK: begin
        w_state_nxt = ((w_err != 3'b000) || w_uncorr) ? REPAIR : IDLE;
      end
      REPAIR: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_repair_wr = (r_state == REPAIR) && r_cls_corr;

  // Write or repair first, then injection flips bits on top of it.
  always_comb begin
    w_base_a = r_copy_a;
    w_base_b = r_copy_b;
    w_base_c = r_copy_c;
    if (w_accept) begin
      w_base_a = wdata_i;
      w_base_b = wdata_i;
      w_base_c = wdata_i;
    end else if (w_repair_wr) begin
      w_base_a = r_voted;
      w_base_b = r_voted;
      w_base_c = r_voted;
    end
    w_nxt_a = w_base_a ^ (inject_i[0] ? inject_mask_i : '0);
    w_nxt_b = w_base_b ^ (inject_i[1] ? inject_mask_i : '0);
    w_nxt_c = w_base_c ^ (inject_i[2] ? inject_mask_i : '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_intv <= IntvReload;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_intv <= IntvReload;
      end else if (r_intv != '0) begin
        r_intv <= r_intv - 1'b1;
      end
    end else if (w_state_nxt == IDLE) begin
      r_intv <= IntvReload;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_copy_a <= '0;
      r_copy_b <= '0;
      r_copy_c <= '0;
    end else begin
      r_copy_a <= w_nxt_a;
      r_copy_b <= w_nxt_b;
      r_copy_c <= w_nxt_c;
    end
  end

  // CHECK captures the vote so REPAIR writes back what was judged, not later upsets.
  always_ff @(posedge clk_i) begin
    if (r_state == CHECK) r_voted <= w_voted;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cls_corr   <= 1'b0;
      r_cls_uncorr <= 1'b0;
    end else if (r_state == CHECK) begin
      r_cls_corr   <= (w_err != 3'b000);
      r_cls_uncorr <= w_uncorr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == REPAIR) begin
      if (r_cls_corr)   r_cnt    <= sat_inc(r_cnt);
      if (r_cls_uncorr) r_sticky <= 1'b1;
    end
  end

  assign wready_o        = w_wready;
  assign scrub_busy_o    = w_busy;
  assign copy_a_o        = r_copy_a;
  assign copy_b_o        = r_copy_b;
  assign copy_c_o        = r_copy_c;
  assign data_o          = w_voted;
  assign error_cba_o     = w_err;
  assign uncorrectable_o = w_uncorr;
  assign uncorr_sticky_o = r_sticky;
  assign corrected_cnt_o = r_cnt;

endmodule

// File: tb/tb_tmr_word_scrubber.sv
// Scoreboard bench for tmr_word_scrubber: a cycle-level behavioural model predicts
// every output after each edge; a negedge monitor pops and compares.
module tb_tmr_word_scrubber;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          wvalid_i = 1'b0;
  logic          wready_o;
  logic [DW-1:0] wdata_i = '0;
  logic [2:0]    inject_i = '0;
  logic [DW-1:0] inject_mask_i = '0;
  logic          clr_i = 1'b0;
  logic [DW-1:0] copy_a_o, copy_b_o, copy_c_o, data_o;
  logic [2:0]    error_cba_o;
  logic          uncorrectable_o, uncorr_sticky_o, scrub_busy_o;
  logic [CW-1:0] corrected_cnt_o;

  tmr_word_scrubber #(.DataWidth(DW), .ScrubInterval(N), .CntWidth(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .wdata_i(wdata_i), .inject_i(inject_i), .inject_mask_i(inject_mask_i),
    .clr_i(clr_i), .copy_a_o(copy_a_o), .copy_b_o(copy_b_o), .copy_c_o(copy_c_o),
    .data_o(data_o), .error_cba_o(error_cba_o), .uncorrectable_o(uncorrectable_o),
    .uncorr_sticky_o(uncorr_sticky_o), .corrected_cnt_o(corrected_cnt_o),
    .scrub_busy_o(scrub_busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] a, b, c, d;
    logic [2:0]    e;
    logic          u, st, wr, busy;
    int            cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Model state: copies, phase (0 idle, 1 check, 2 repair), idle countdown,
  // verdict captured in the check phase (0 clean, 1 correctable, 2 uncorrectable).
  logic [DW-1:0] m_a, m_b, m_c, m_vote;
  int m_phase, m_intv, m_cls, m_cnt;
  bit m_sticky;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void vote(input logic [DW-1:0] a, b, c,
                               output logic [DW-1:0] w, output logic [2:0] e, output logic u);
    w = a; e = 3'b000; u = 1'b0;
    if (a == b && b == c) begin
      w = a;
    end else if (a == b) begin
      w = a; e = 3'b100;
    end else if (a == c) begin
      w = a; e = 3'b010;
    end else if (b == c) begin
      w = b; e = 3'b001;
    end else begin
      u = 1'b1;
    end
  endfunction

  task automatic model_step(input bit rst, wv, input logic [DW-1:0] wd,
                            input logic [2:0] inj, input logic [DW-1:0] mask, input bit clr);
    logic [DW-1:0] na, nb, nc, vw;
    logic [2:0] ve;
    logic vu;
    if (rst) begin
      m_a = '0; m_b = '0; m_c = '0; m_phase = 0; m_intv = N - 1;
      m_cls = 0; m_cnt = 0; m_sticky = 0;
      return;
    end
    na = m_a; nb = m_b; nc = m_c;
    case (m_phase)
      0: begin
        if (wv) begin
          na = wd; nb = wd; nc = wd; m_intv = N - 1;
        end else if (m_intv == 0) begin
          m_phase = 1;
        end else begin
          m_intv--;
        end
      end
      1: begin
        vote(m_a, m_b, m_c, vw, ve, vu);
        m_vote = vw;
        m_cls = vu ? 2 : ((ve != 3'b000) ? 1 : 0);
        if (m_cls != 0) m_phase = 2;
        else begin m_phase = 0; m_intv = N - 1; end
      end
      default: begin
        if (m_cls == 1) begin
          na = m_vote; nb = m_vote; nc = m_vote;
          if (m_cnt < CMAX) m_cnt++;
        end else if (m_cls == 2) begin
          m_sticky = 1;
        end
        m_phase = 0; m_intv = N - 1;
      end
    endcase
    if (clr) begin m_sticky = 0; m_cnt = 0; end
    m_a = na ^ (inj[0] ? mask : '0);
    m_b = nb ^ (inj[1] ? mask : '0);
    m_c = nc ^ (inj[2] ? mask : '0);
  endtask

  task automatic step(input bit rst, wv, input logic [DW-1:0] wd,
                      input logic [2:0] inj, input logic [DW-1:0] mask, input bit clr);
    exp_t x;
    rst_i = rst; wvalid_i = wv; wdata_i = wd; inject_i = inj; inject_mask_i = mask; clr_i = clr;
    @(posedge clk_i);
    #1;
    model_step(rst, wv, wd, inj, mask, clr);
    x.a = m_a; x.b = m_b; x.c = m_c;
    vote(m_a, m_b, m_c, x.d, x.e, x.u);
    x.st = m_sticky; x.cnt = m_cnt; x.wr = (m_phase == 0); x.busy = (m_phase != 0);
    q.push_back(x);
  endtask

  task automatic idle();
    step(0, 0, '0, 3'b000, '0, 0);
  endtask

  task automatic wait_phase(input int p, input string name);
    int k = 0;
    while (m_phase != p && k < N + 3) begin idle(); k++; end
    chk(name, m_phase, p);
  endtask

  task automatic wait_cnt(input int target, input string name);
    int k = 0;
    while (corrected_cnt_o != CW'(target) && k < N + 2) begin idle(); k++; end
    chk(name, corrected_cnt_o, target);
  endtask

  // Scoreboard monitor
  always @(negedge clk_i) begin
    while (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("sb_copy_a", copy_a_o, x.a);
      chk("sb_copy_b", copy_b_o, x.b);
      chk("sb_copy_c", copy_c_o, x.c);
      chk("sb_data", data_o, x.d);
      chk("sb_err", error_cba_o, x.e);
      chk("sb_uncorr", uncorrectable_o, x.u);
      chk("sb_sticky", uncorr_sticky_o, x.st);
      chk("sb_cnt", corrected_cnt_o, x.cnt);
      chk("sb_wready", wready_o, x.wr);
      chk("sb_busy", scrub_busy_o, x.busy);
    end
  end

  initial begin
    int nbusy;
    // Reset and write
    step(1, 0, '0, 3'b000, '0, 0);
    step(1, 0, '0, 3'b000, '0, 0);
    chk("rst_copy_a", copy_a_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_wready", wready_o, 1);
    chk("rst_busy", scrub_busy_o, 0);
    chk("rst_cnt", corrected_cnt_o, 0);
    step(0, 1, 32'hDEADBEEF, 3'b000, '0, 0);
    chk("wr_copy_c", copy_c_o, 32'hDEADBEEF);
    chk("wr_data", data_o, 32'hDEADBEEF);
    nbusy = 0;
    for (int i = 0; i < 3 * (N + 1); i++) begin
      idle();
      if (scrub_busy_o) nbusy++;
    end
    chk("clean_pass_busy_cycles", nbusy, 3);
    chk("clean_pass_cnt", corrected_cnt_o, 0);

    // Single-copy upset
    step(0, 1, 32'h12345678, 3'b000, '0, 0);
    step(0, 0, '0, 3'b010, 32'h00000100, 0);
    chk("upset_copy_b", copy_b_o, 32'h12345778);
    chk("upset_data", data_o, 32'h12345678);
    chk("upset_err", error_cba_o, 3'b010);
    wait_cnt(1, "repair_cnt");
    chk("repair_copy_b", copy_b_o, 32'h12345678);
    chk("repair_err", error_cba_o, 3'b000);

    // Double-copy upset
    step(0, 1, 32'hCAFEF00D, 3'b000, '0, 0);
    step(0, 0, '0, 3'b001, 32'h1, 0);
    step(0, 0, '0, 3'b010, 32'h2, 0);
    chk("dbl_uncorr", uncorrectable_o, 1);
    wait_phase(2, "dbl_reach_repair");
    idle();
    chk("dbl_sticky", uncorr_sticky_o, 1);
    chk("dbl_copy_a_kept", copy_a_o, 32'hCAFEF00C);
    chk("dbl_cnt_kept", corrected_cnt_o, 1);
    step(0, 1, 32'h0, 3'b000, '0, 0);
    chk("dbl_write_uncorr", uncorrectable_o, 0);
    chk("dbl_write_sticky", uncorr_sticky_o, 1);
    step(0, 0, '0, 3'b000, '0, 1);
    chk("clr_sticky", uncorr_sticky_o, 0);
    chk("clr_cnt", corrected_cnt_o, 0);

    // Handshake held through CHECK and REPAIR
    step(0, 1, 32'h11111111, 3'b000, '0, 0);
    step(0, 0, '0, 3'b100, 32'hF0, 0);
    wait_phase(1, "hs_reach_check");
    chk("hs_wready_check", wready_o, 0);
    step(0, 1, 32'hA5A5A5A5, 3'b000, '0, 0);
    chk("hs_wready_repair", wready_o, 0);
    step(0, 1, 32'hA5A5A5A5, 3'b000, '0, 0);
    chk("hs_not_yet_written", copy_a_o, 32'h11111111);
    chk("hs_wready_idle", wready_o, 1);
    step(0, 1, 32'hA5A5A5A5, 3'b000, '0, 0);
    chk("hs_copy_b", copy_b_o, 32'hA5A5A5A5);
    idle();

    // Reset during REPAIR
    step(0, 1, 32'h0F0F0F0F, 3'b000, '0, 0);
    step(0, 0, '0, 3'b001, 32'hFF, 0);
    wait_phase(2, "rst_reach_repair");
    step(1, 0, '0, 3'b000, '0, 0);
    chk("midrst_copy_a", copy_a_o, 0);
    chk("midrst_copy_b", copy_b_o, 0);
    chk("midrst_cnt", corrected_cnt_o, 0);
    chk("midrst_busy", scrub_busy_o, 0);
    idle();

    // Counter saturation
    for (int r = 0; r < 5; r++) begin
      step(0, 1, 32'h55 + r, 3'b000, '0, 0);
      step(0, 0, '0, 3'b001, 32'h1, 0);
      wait_cnt((r + 1 > CMAX) ? CMAX : r + 1, "sat_step_cnt");
      idle();
    end
    chk("sat_cnt", corrected_cnt_o, CMAX);
    step(0, 0, '0, 3'b000, '0, 1);
    chk("sat_clr", corrected_cnt_o, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit rr, wv, cl;
      logic [2:0] inj;
      rr  = ($urandom_range(0, 99) == 0);
      wv  = ($urandom_range(0, 5) == 0);
      cl  = ($urandom_range(0, 29) == 0);
      inj = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      step(rr, wv, $urandom, inj, ($urandom_range(0, 1) == 0) ? DW'(1 << $urandom_range(0, 31)) : $urandom, cl);
    end

    @(negedge clk_i);
    #1;
    chk("sb_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
